// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the two-master SRAM port arbiter.
package sram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam int MAX_WAIT = 15;
  localparam int M0       = 0;
  localparam int M1       = 1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; grant is combinational, last_grant advances on accept.
module rr_arbiter2
  import sram_arb_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  input  logic       req0,
  input  logic       req1,
  input  logic       accept,
  output logic [1:0] grant
);

  // 1 = M1 was granted last, so M0 wins the first tie after reset
  logic last_grant;

  always_comb begin
    grant = 2'b00;
    if (req0 && req1) begin
      grant = last_grant ? 2'b01 : 2'b10;
    end else if (req0) begin
      grant = 2'b01;
    end else if (req1) begin
      grant = 2'b10;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      last_grant <= 1'b1;
    end else if (accept && (grant != 2'b00)) begin
      last_grant <= grant[M1];
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Arbitrates two masters onto a single-port RAM: one access cycle per grant,
// optional wait states, registered read data returned with a data_ok pulse.
//
// state  | meaning
// IDLE   | accept a request from the round-robin winner
// WAIT   | wait-state countdown (counter runs 1..WAIT_CYCLES)
// ACCESS | drive RAM for one cycle, capture read data
// RESP   | data_ok pulse to the owner
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 32,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  m0_req,
  input  logic                  m0_wr,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_addr_ok,
  output logic                  m0_data_ok,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  input  logic                  m1_req,
  input  logic                  m1_wr,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_addr_ok,
  output logic                  m1_data_ok,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_a,
  output logic [DATA_WIDTH-1:0] ram_d,
  input  logic [DATA_WIDTH-1:0] ram_spo
);

  localparam int         WAIT_EFF  = (WAIT_CYCLES > MAX_WAIT) ? MAX_WAIT : WAIT_CYCLES;
  localparam logic [3:0] WAIT_LAST = 4'(WAIT_EFF);

  state_t                state, state_nxt;
  logic [3:0]            cnt;
  logic                  wr_q;
  logic                  owner_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  accept;
  logic [1:0]            grant;

  // resetn in the term keeps addr_ok low while reset is held
  assign accept = (state == IDLE) && resetn && (m0_req || m1_req);

  rr_arbiter2 u_rr (
    .clk    (clk),
    .resetn (resetn),
    .req0   (m0_req),
    .req1   (m1_req),
    .accept (accept),
    .grant  (grant)
  );

  assign m0_addr_ok = accept && grant[M0];
  assign m1_addr_ok = accept && grant[M1];

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = (WAIT_EFF > 0) ? WAIT : ACCESS;
      WAIT:    if (cnt == WAIT_LAST) state_nxt = ACCESS;
      ACCESS:  state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      wr_q    <= 1'b0;
      owner_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (accept) begin
            owner_q <= grant[M1];
            wr_q    <= grant[M1] ? m1_wr    : m0_wr;
            addr_q  <= grant[M1] ? m1_addr  : m0_addr;
            wdata_q <= grant[M1] ? m1_wdata : m0_wdata;
            cnt     <= 4'd1;
          end
        end
        WAIT:    if (cnt != WAIT_LAST) cnt <= cnt + 4'd1;
        ACCESS:  rdata_q <= wr_q ? '0 : ram_spo;
        RESP:    cnt <= 4'd0;
        default: cnt <= 4'd0;
      endcase
    end
  end

  // state is reset asynchronously, so ram_we falls the moment resetn does
  assign ram_we = (state == ACCESS) && wr_q;
  assign ram_a  = addr_q;
  assign ram_d  = wdata_q;

  assign m0_data_ok = (state == RESP) && (owner_q == 1'(M0));
  assign m1_data_ok = (state == RESP) && (owner_q == 1'(M1));
  assign m0_rdata   = (owner_q == 1'(M0)) ? rdata_q : '0;
  assign m1_rdata   = (owner_q == 1'(M1)) ? rdata_q : '0;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: instance 0 without wait states, instance 1 with three.
module tb_sram_port_arbiter;

  localparam int AW = 16;
  localparam int DW = 32;

  logic clk;
  logic resetn;
  int   cyc;
  int   n_tests;
  int   n_fail;

  logic [1:0]    req   [2];
  logic [1:0]    wr    [2];
  logic [AW-1:0] addr  [2][2];
  logic [DW-1:0] wdata [2][2];
  logic [DW-1:0] rdata [2][2];
  logic [1:0]    aok   [2];
  logic [1:0]    dok   [2];
  logic          we    [2];
  logic [AW-1:0] ram_a [2];
  logic [DW-1:0] ram_d [2];
  logic [DW-1:0] spo   [2];
  logic [DW-1:0] ram   [2][0:1023];
  logic          ram_init;

  typedef struct {
    int            owner;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            due;
  } sb_t;

  sb_t           sbq [2][$];
  logic [DW-1:0] refm [int];

  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    if (a == 16'h0010) return 32'hDEADBEEF;
    return {a ^ 16'hA5A5, a};
  endfunction

  function automatic logic [DW-1:0] ref_rd(input int d, input logic [AW-1:0] a);
    int key;
    key = d * 65536 + int'(a);
    if (refm.exists(key)) return refm[key];
    return init_val(a);
  endfunction

  sram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .resetn(resetn),
    .m0_req(req[0][0]), .m0_wr(wr[0][0]), .m0_addr(addr[0][0]), .m0_wdata(wdata[0][0]),
    .m0_addr_ok(aok[0][0]), .m0_data_ok(dok[0][0]), .m0_rdata(rdata[0][0]),
    .m1_req(req[0][1]), .m1_wr(wr[0][1]), .m1_addr(addr[0][1]), .m1_wdata(wdata[0][1]),
    .m1_addr_ok(aok[0][1]), .m1_data_ok(dok[0][1]), .m1_rdata(rdata[0][1]),
    .ram_we(we[0]), .ram_a(ram_a[0]), .ram_d(ram_d[0]), .ram_spo(spo[0])
  );

  sram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_CYCLES(3)) dut3 (
    .clk(clk), .resetn(resetn),
    .m0_req(req[1][0]), .m0_wr(wr[1][0]), .m0_addr(addr[1][0]), .m0_wdata(wdata[1][0]),
    .m0_addr_ok(aok[1][0]), .m0_data_ok(dok[1][0]), .m0_rdata(rdata[1][0]),
    .m1_req(req[1][1]), .m1_wr(wr[1][1]), .m1_addr(addr[1][1]), .m1_wdata(wdata[1][1]),
    .m1_addr_ok(aok[1][1]), .m1_data_ok(dok[1][1]), .m1_rdata(rdata[1][1]),
    .ram_we(we[1]), .ram_a(ram_a[1]), .ram_d(ram_d[1]), .ram_spo(spo[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM models: combinational read, write at the clock edge
  always @(posedge clk) begin
    if (ram_init !== 1'b1) begin
      for (int d = 0; d < 2; d++)
        for (int i = 0; i < 1024; i++) ram[d][i] <= init_val(AW'(i));
      ram_init <= 1'b1;
    end else begin
      for (int d = 0; d < 2; d++)
        if (we[d]) ram[d][ram_a[d][9:0]] <= ram_d[d];
    end
  end
  assign spo[0] = ram[0][ram_a[0][9:0]];
  assign spo[1] = ram[1][ram_a[1][9:0]];

  // scoreboard: push on addr_ok, pop and check on data_ok
  always @(negedge clk) begin
    sb_t           e;
    int            m;
    logic [DW-1:0] exp_d;
    if (!resetn) begin
      sbq[0].delete();
      sbq[1].delete();
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (aok[d] != 2'b00) begin
          n_tests++;
          if (aok[d] == 2'b11) begin
            n_fail++;
            $display("FAIL addr_ok_onehot dut%0d: got %b, required one master only", d, aok[d]);
          end
          for (int k = 0; k < 2; k++) begin
            if (aok[d][k]) begin
              e.owner = k;
              e.wr    = wr[d][k];
              e.addr  = addr[d][k];
              e.wdata = wdata[d][k];
              e.due   = cyc + 2 + ((d == 0) ? 0 : 3);
              sbq[d].push_back(e);
            end
          end
        end
        if (dok[d] != 2'b00) begin
          n_tests++;
          if (sbq[d].size() == 0 || dok[d] == 2'b11) begin
            n_fail++;
            $display("FAIL data_ok_expected dut%0d: got data_ok=%b with %0d pending, required a single pending owner",
                     d, dok[d], sbq[d].size());
          end else begin
            e = sbq[d].pop_front();
            m = dok[d][1] ? 1 : 0;
            n_tests++;
            if (m != e.owner || cyc != e.due) begin
              n_fail++;
              $display("FAIL data_ok_owner_latency dut%0d: got m%0d at cycle %0d, required m%0d at cycle %0d",
                       d, m, cyc, e.owner, e.due);
            end
            exp_d = e.wr ? '0 : ref_rd(d, e.addr);
            n_tests++;
            if (rdata[d][m] !== exp_d || rdata[d][1-m] !== '0) begin
              n_fail++;
              $display("FAIL rdata dut%0d: got owner=%h other=%h, required owner=%h other=0",
                       d, rdata[d][m], rdata[d][1-m], exp_d);
            end
            if (e.wr) refm[d * 65536 + int'(e.addr)] = e.wdata;
          end
        end
      end
    end
  end

  task automatic drive(input int d, input int m, input logic w, input logic [AW-1:0] a,
                       input logic [DW-1:0] wd);
    req[d][m]   = 1'b1;
    wr[d][m]    = w;
    addr[d][m]  = a;
    wdata[d][m] = wd;
  endtask

  task automatic run_txn(input int d, input int m, input logic w, input logic [AW-1:0] a,
                         input logic [DW-1:0] wd, output logic [DW-1:0] got,
                         output int we_cnt, output bit ok);
    bit acc;
    acc    = 1'b0;
    ok     = 1'b0;
    we_cnt = 0;
    got    = '0;
    @(posedge clk);
    #1 drive(d, m, w, a, wd);
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (we[d]) we_cnt++;
      if (acc && dok[d][m]) begin
        got = rdata[d][m];
        ok  = 1'b1;
      end
      if (aok[d][m]) begin
        acc = 1'b1;
        @(posedge clk);
        #1 req[d][m] = 1'b0;
      end
    end
    req[d][m] = 1'b0;
  endtask

  task automatic drain();
    int i;
    i = 0;
    while ((sbq[0].size() != 0 || sbq[1].size() != 0) && i < 30) begin
      @(negedge clk);
      i++;
    end
    n_tests++;
    if (sbq[0].size() != 0 || sbq[1].size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d/%0d pending, required 0/0", sbq[0].size(), sbq[1].size());
    end
  endtask

  task automatic check_all_zero(input string tag);
    for (int d = 0; d < 2; d++) begin
      n_tests++;
      if ({aok[d], dok[d], we[d]} !== 5'b0 || ram_a[d] !== '0 || ram_d[d] !== '0 ||
          rdata[d][0] !== '0 || rdata[d][1] !== '0) begin
        n_fail++;
        $display("FAIL %s dut%0d: got aok=%b dok=%b we=%b a=%h d=%h r0=%h r1=%h, required all 0",
                 tag, d, aok[d], dok[d], we[d], ram_a[d], ram_d[d], rdata[d][0], rdata[d][1]);
      end
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    req[0] = 2'b11;
    req[1] = 2'b11;
    repeat (3) @(negedge clk);
    check_all_zero("reset_outputs");
    req[0] = 2'b00;
    req[1] = 2'b00;
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_contention();
    int order[$];
    int exp_order[4];
    exp_order = '{0, 1, 0, 1};
    @(posedge clk);
    #1 drive(0, 0, 1'b0, 16'h0100, '0);
    drive(0, 1, 1'b0, 16'h0200, '0);
    for (int i = 0; i < 60 && order.size() < 4; i++) begin
      @(negedge clk);
      if (aok[0] != 2'b00) begin
        order.push_back(aok[0][1] ? 1 : 0);
        @(posedge clk);
        #1;
        if (order.size() == 4) req[0] = 2'b00;
        else addr[0][order[order.size()-1]] += 16'd1;
      end
    end
    req[0] = 2'b00;
    n_tests++;
    if (order.size() != 4) begin
      n_fail++;
      $display("FAIL contention_count: got %0d grants, required 4", order.size());
    end
    for (int i = 0; i < 4 && i < order.size(); i++) begin
      n_tests++;
      if (order[i] != exp_order[i]) begin
        n_fail++;
        $display("FAIL contention_order[%0d]: got m%0d, required m%0d", i, order[i], exp_order[i]);
      end
    end
    drain();
  endtask

  task automatic test_single_read();
    @(posedge clk);
    #1 drive(0, 0, 1'b0, 16'h0010, '0);
    @(negedge clk);
    n_tests++;
    if (aok[0] !== 2'b01) begin
      n_fail++;
      $display("FAIL single_read_addr_ok: got %b, required 01", aok[0]);
    end
    @(posedge clk);
    #1 req[0][0] = 1'b0;
    @(negedge clk);
    n_tests++;
    if (ram_a[0] !== 16'h0010 || we[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL single_read_access: got a=%h we=%b, required a=0010 we=0", ram_a[0], we[0]);
    end
    @(negedge clk);
    n_tests++;
    if (dok[0] !== 2'b01 || rdata[0][0] !== 32'hDEADBEEF || rdata[0][1] !== '0) begin
      n_fail++;
      $display("FAIL single_read_resp: got dok=%b r0=%h r1=%h, required dok=01 r0=deadbeef r1=0",
               dok[0], rdata[0][0], rdata[0][1]);
    end
    drain();
  endtask

  task automatic test_write_read();
    logic [DW-1:0] got;
    int            wec;
    bit            ok;
    run_txn(0, 1, 1'b1, 16'h0020, 32'h12345678, got, wec, ok);
    n_tests++;
    if (!ok || wec != 1 || got !== '0) begin
      n_fail++;
      $display("FAIL write_txn: got done=%0d we_cycles=%0d rdata=%h, required done=1 we_cycles=1 rdata=0",
               ok, wec, got);
    end
    n_tests++;
    if (ram[0][10'h020] !== 32'h12345678) begin
      n_fail++;
      $display("FAIL write_ram: got %h, required 12345678", ram[0][10'h020]);
    end
    run_txn(0, 1, 1'b0, 16'h0020, 32'h0, got, wec, ok);
    n_tests++;
    if (!ok || wec != 0 || got !== 32'h12345678) begin
      n_fail++;
      $display("FAIL read_back: got done=%0d we_cycles=%0d rdata=%h, required done=1 we_cycles=0 rdata=12345678",
               ok, wec, got);
    end
    drain();
  endtask

  task automatic test_wait_states();
    logic [DW-1:0] got;
    int            wec;
    bit            ok;
    @(posedge clk);
    #1 drive(1, 0, 1'b0, 16'h0030, '0);
    @(negedge clk);
    n_tests++;
    if (aok[1] !== 2'b01) begin
      n_fail++;
      $display("FAIL wait_addr_ok: got %b, required 01", aok[1]);
    end
    @(posedge clk);
    #1 req[1][0] = 1'b0;
    drive(1, 1, 1'b0, 16'h0031, '0);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      n_tests++;
      if (aok[1] !== 2'b00 || dok[1] !== ((k == 5) ? 2'b01 : 2'b00)) begin
        n_fail++;
        $display("FAIL wait_window T+%0d: got aok=%b dok=%b, required aok=00 dok=%s",
                 k, aok[1], dok[1], (k == 5) ? "01" : "00");
      end
    end
    @(negedge clk);
    n_tests++;
    if (aok[1] !== 2'b10) begin
      n_fail++;
      $display("FAIL wait_next_accept: got %b at T+6, required 10", aok[1]);
    end
    @(posedge clk);
    #1 req[1] = 2'b00;
    drain();
    run_txn(1, 0, 1'b1, 16'h0034, 32'h0BADF00D, got, wec, ok);
    n_tests++;
    if (!ok || wec != 1 || ram[1][10'h034] !== 32'h0BADF00D) begin
      n_fail++;
      $display("FAIL wait_write: got done=%0d we_cycles=%0d ram=%h, required done=1 we_cycles=1 ram=0badf00d",
               ok, wec, ram[1][10'h034]);
    end
    drain();
  endtask

  task automatic test_reset_midop();
    int seen;
    @(posedge clk);
    #1 drive(1, 0, 1'b1, 16'h0040, 32'hCAFEF00D);
    @(negedge clk);
    n_tests++;
    if (aok[1] !== 2'b01) begin
      n_fail++;
      $display("FAIL midop_addr_ok: got %b, required 01", aok[1]);
    end
    @(posedge clk);
    #1 req[1][0] = 1'b0;
    #2 resetn = 1'b0;
    #1 check_all_zero("midop_async");
    repeat (2) @(negedge clk);
    check_all_zero("midop_held");
    resetn = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (dok[1] != 2'b00 || we[1]) seen++;
    end
    n_tests++;
    if (seen != 0 || ram[1][10'h040] !== init_val(16'h0040)) begin
      n_fail++;
      $display("FAIL midop_dropped: got %0d data_ok/we cycles, ram=%h, required 0 and %h",
               seen, ram[1][10'h040], init_val(16'h0040));
    end
    @(posedge clk);
    #1 drive(1, 0, 1'b0, 16'h0041, '0);
    drive(1, 1, 1'b0, 16'h0042, '0);
    @(negedge clk);
    n_tests++;
    if (aok[1] !== 2'b01) begin
      n_fail++;
      $display("FAIL midop_regrant: got %b, required 01", aok[1]);
    end
    @(posedge clk);
    #1 req[1][0] = 1'b0;
    repeat (4) @(negedge clk);
    @(negedge clk);
    n_tests++;
    if (dok[1] !== 2'b01 || rdata[1][0] !== init_val(16'h0041)) begin
      n_fail++;
      $display("FAIL midop_latency: got dok=%b r0=%h at T+5, required 01 and %h",
               dok[1], rdata[1][0], init_val(16'h0041));
    end
    @(negedge clk);
    n_tests++;
    if (aok[1] !== 2'b10) begin
      n_fail++;
      $display("FAIL midop_m1_accept: got %b, required 10", aok[1]);
    end
    @(posedge clk);
    #1 req[1] = 2'b00;
    drain();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    for (int d = 0; d < 2; d++) begin
      req[d] = 2'b00;
      wr[d]  = 2'b00;
      for (int m = 0; m < 2; m++) begin
        addr[d][m]  = '0;
        wdata[d][m] = '0;
      end
    end
    test_reset();
    test_contention();
    test_single_read();
    test_write_read();
    test_wait_states();
    test_reset_midop();
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Two-master arbiter and sequencer for a single-port RAM with combinational read and synchronous write, as used for the SoC testbench instruction and data RAMs. It accepts requests from two masters on an addr_ok/data_ok handshake, grants one at a time round-robin, and drives the RAM's address, write-enable and write-data lines for exactly one access cycle. It also registers the read data and returns it with a one-cycle data_ok pulse. Optional wait states model slower memory.

## Interface
- ADDR_WIDTH, 16, RAM word-address width
- DATA_WIDTH, 32, RAM data width
- WAIT_CYCLES, 0, extra idle cycles inserted between acceptance and RAM access (0..15)

- clk  in  1  system clock, all state on rising edge
- resetn  in  1  asynchronous active-low reset
- m0_req / m1_req  in  1  master n request valid
- m0_wr / m1_wr  in  1  1 = write, 0 = read
- m0_addr / m1_addr  in  ADDR_WIDTH  word address
- m0_wdata / m1_wdata  in  DATA_WIDTH  write data
- m0_addr_ok / m1_addr_ok  out  1  request accepted this cycle
- m0_data_ok / m1_data_ok  out  1  one-cycle completion pulse
- m0_rdata / m1_rdata  out  DATA_WIDTH  read data, valid with data_ok
- ram_we  out  1  RAM write enable
- ram_a  out  ADDR_WIDTH  RAM address
- ram_d  out  DATA_WIDTH  RAM write data
- ram_spo  in  DATA_WIDTH  RAM combinational read data

## Operation
- FSM states: IDLE, WAIT, ACCESS, RESP.
- IDLE
  - If any req is high, assert addr_ok for the winner only.
  - Latch the winner's wr, addr and wdata, and record the owner.
  - Go to WAIT if WAIT_CYCLES > 0, else to ACCESS.
- WAIT
  - The counter counts up from 1.
  - Go to ACCESS when the count reaches WAIT_CYCLES.
  - The counter clears on entry to IDLE.
- ACCESS, exactly one cycle
  - ram_a = latched addr; ram_d = latched wdata; ram_we = latched wr.
  - Read: capture ram_spo into the rdata register at the clock edge.
  - Write: the RAM commits at the same edge; the rdata register is loaded with 0.
  - Then go to RESP.
- RESP, one cycle
  - Assert data_ok for the owner only; owner rdata = rdata register.
  - Go to IDLE.
  - No new request is accepted in RESP.
- Round robin
  - last_grant register resets to 1.
  - When both masters request, grant the master that is not last_grant.
  - A single requester is always granted.
  - last_grant updates on acceptance.
- Outside ACCESS: ram_we = 0; ram_a and ram_d hold their latched values.
- Non-owner rdata is 0; non-owner data_ok and addr_ok are 0.
- Masters hold req and its payload until addr_ok. Payload may change after acceptance.

## Timing
- Reset values
  - state = IDLE, last_grant = 1, counter = 0.
  - rdata register = 0; latched addr, wdata and wr = 0.
  - All addr_ok, data_ok and ram_we = 0.
  - addr_ok is gated low while resetn is low.
- Latency, with acceptance at cycle T
  - ACCESS at T+1+WAIT_CYCLES.
  - data_ok at T+2+WAIT_CYCLES.
  - Next acceptance no earlier than T+3+WAIT_CYCLES.
- addr_ok is combinational from req in IDLE. No other output depends combinationally on inputs.
- Simultaneous requests
  - After reset, m0 wins.
  - With both masters requesting continuously, grants alternate m0, m1, m0 and so on.
- Reset mid-operation
  - Immediate return to IDLE; the pending transaction is dropped.
  - ram_we drops asynchronously, so no write is issued.
  - No data_ok is generated for the dropped transaction.
- The counter width is 4 bits; WAIT_CYCLES above 15 is illegal.

## Structure
- Package sram_arb_pkg
  - State enum (IDLE, WAIT, ACCESS, RESP).
  - MAX_WAIT = 15 constant.
  - Master index constants M0 = 0, M1 = 1.
- Sub-module rr_arbiter2
  - Inputs: two req, clk, resetn, accept.
  - Outputs: one-hot grant.
  - Owns the last_grant register.
- The FSM, counter, latches and rdata register live in sram_port_arbiter.

## Test plan
- Single read: RAM word 0x10 = 0xDEADBEEF, WAIT_CYCLES = 0, m0 read 0x10 at T -> m0_addr_ok at T, ram_a = 0x10 with ram_we = 0 at T+1, m0_data_ok with m0_rdata = 0xDEADBEEF at T+2, m1 outputs 0.
- Write then read: m1 writes 0x12345678 to 0x20, then reads 0x20 -> ram_we high exactly one cycle; second data_ok returns 0x12345678; write data_ok carries rdata 0.
- Contention: both masters request continuously from reset, 4 transactions -> grant order m0, m1, m0, m1; each data_ok goes only to its owner.
- Wait states: WAIT_CYCLES = 3, m0 read accepted at T -> ACCESS at T+4, data_ok at T+5; no addr_ok for either master in T+1..T+5.
- Reset mid-op: m0 write accepted, resetn pulled low during WAIT -> RAM word unchanged, no data_ok, all outputs 0; next request after reset is granted to m0 with the same latency as from power-up.
